// File: rtl/rs_ctrl_pkg.sv
// Shared types and helpers for the RS flip-flop bank controller.
// Optional feature macro used by rs_ff_ctrl: RS_FF_CTRL_VERIFY_EN (Q read-back check).
package rs_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_VERIFY = 2'd3
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  // Ceiling log2, never below 1 so derived widths stay legal.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after rr wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int RRW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [RRW-1:0]  rr,
  output logic [NREQ-1:0] grant,
  output logic [RRW-1:0]  winner
);

  int   j;
  logic found;

  // Scan NREQ positions starting at rr, wrapping, and take the first hit.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    j      = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(rr) + i) % NREQ;
      if (!found && req[j[RRW-1:0]]) begin
        found               = 1'b1;
        grant[j[RRW-1:0]]   = 1'b1;
        winner              = j[RRW-1:0];
      end
    end
  end

endmodule

// File: rtl/rs_ff_ctrl.sv
// Round-robin controller that drives single S/R pulses into an RS flip-flop bank.
// Build option: define RS_FF_CTRL_VERIFY_EN to add a settle cycle and a Q read-back check.
module rs_ff_ctrl
  import rs_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFF   = 8,
  parameter int PULSE = 1,
  parameter int IDXW  = clog2(NFF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 busy,
  output logic [NFF-1:0]       S,
  output logic [NFF-1:0]       R,
  input  logic [NFF-1:0]       Q
);

  localparam int RRW = clog2(NREQ);
  localparam int CW  = 2;

`ifdef RS_FF_CTRL_VERIFY_EN
  localparam state_t POST_PULSE = ST_SETTLE;
`else
  localparam state_t POST_PULSE = ST_VERIFY;
`endif

  state_t          state, nstate;
  logic [RRW-1:0]  rr, win, win_c;
  logic [NREQ-1:0] grant_c;
  logic            op_q, oor_q, op_sel, oor_in;
  logic [IDXW-1:0] idx_q, idx_sel;
  logic [CW-1:0]   cnt;
  logic            mismatch;

  rr_arbiter #(.NREQ(NREQ), .RRW(RRW)) u_arb (
    .req    (req),
    .rr     (rr),
    .grant  (grant_c),
    .winner (win_c)
  );

  // The winner's request fields, and whether its index lands outside the bank.
  assign op_sel  = op[win_c];
  assign idx_sel = IDXW'(idx >> (int'(win_c) * IDXW));
  assign oor_in  = (int'(idx_sel) >= NFF);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nstate;
  end

  // Next-state logic; out-of-range requests skip straight to VERIFY.
  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE:   if (|req) nstate = oor_in ? ST_VERIFY : ST_PULSE;
      ST_PULSE:  if (cnt == '0) nstate = POST_PULSE;
`ifdef RS_FF_CTRL_VERIFY_EN
      ST_SETTLE: nstate = ST_VERIFY;
`endif
      ST_VERIFY: nstate = ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  // Grant capture, rr advance, pulse counter and the registered S/R lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr    <= '0;
      win   <= '0;
      op_q  <= 1'b0;
      idx_q <= '0;
      oor_q <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      R     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (|req) begin
          win   <= win_c;
          op_q  <= op_sel;
          idx_q <= idx_sel;
          oor_q <= oor_in;
          rr    <= (win_c == RRW'(NREQ - 1)) ? '0 : win_c + RRW'(1);
          cnt   <= CW'(PULSE - 1);
          // Only one of S/R is ever loaded, and only one bit of it.
          if (!oor_in) begin
            if (op_sel == OP_SET) S <= NFF'(1) << idx_sel;
            else                  R <= NFF'(1) << idx_sel;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            S <= '0;
            R <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RS_FF_CTRL_VERIFY_EN
  assign mismatch = !oor_q && ((|(Q & (NFF'(1) << idx_q))) != op_q);
`else
  assign mismatch = 1'b0;
  logic unused_q;
  assign unused_q = ^Q;
`endif

  // Outputs decoded from state; ack/err only exist during VERIFY.
  always_comb begin
    ack  = '0;
    err  = 1'b0;
    busy = (state != ST_IDLE);
    if (state == ST_VERIFY) begin
      ack[win] = 1'b1;
      err      = oor_q | mismatch;
    end
  end

endmodule

// File: tb/tb_rs_ff_ctrl.sv
// Directed scoreboard bench for rs_ff_ctrl: instance A (NFF=8, PULSE=1) and instance B (NFF=6, PULSE=4).
module tb_rs_ff_ctrl;

  localparam int NREQ    = 4;
  localparam int PULSE_A = 1;
  localparam int PULSE_B = 4;
`ifdef RS_FF_CTRL_VERIFY_EN
  localparam int VX = 1;
`else
  localparam int VX = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [3:0]  req_a, op_a, ack_a, req_b, op_b, ack_b;
  logic [11:0] idx_a, idx_b;
  logic        err_a, busy_a, err_b, busy_b;
  logic [7:0]  s_a, r_a, q_a = '0, stuck_a;
  logic [5:0]  s_b, r_b, q_b = '0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] ack;
    logic       err;
    int         lat;
  } exp_t;
  exp_t sb[$];

  rs_ff_ctrl #(.NREQ(NREQ), .NFF(8), .PULSE(PULSE_A)) dut_a (
    .clk(clk), .rst_n(rst_a), .req(req_a), .op(op_a), .idx(idx_a),
    .ack(ack_a), .err(err_a), .busy(busy_a), .S(s_a), .R(r_a), .Q(q_a)
  );

  rs_ff_ctrl #(.NREQ(NREQ), .NFF(6), .PULSE(PULSE_B)) dut_b (
    .clk(clk), .rst_n(rst_b), .req(req_b), .op(op_b), .idx(idx_b),
    .ack(ack_b), .err(err_b), .busy(busy_b), .S(s_b), .R(r_b), .Q(q_b)
  );

  // Behavioural RS banks; stuck_a forces selected Q bits low.
  always @(posedge clk) begin
    q_a <= ((q_a & ~r_a) | s_a) & ~stuck_a;
    q_b <= (q_b & ~r_b) | s_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every-cycle invariants and the S/R pulse width on instance A.
  int run_a = 0;
  always @(negedge clk) begin
    chk("sr_overlap_a", s_a & r_a, 0);
    chk("sr_onehot_a", ($countones(s_a | r_a) <= 1), 1);
    chk("ack_onehot_a", ($countones(ack_a) <= 1), 1);
    chk("err_no_ack_a", err_a & ~(|ack_a), 0);
    chk("sr_overlap_b", s_b & r_b, 0);
    chk("sr_onehot_b", ($countones(s_b | r_b) <= 1), 1);
    chk("ack_onehot_b", ($countones(ack_b) <= 1), 1);
    if ((s_a | r_a) != 0) run_a++;
    else if (run_a > 0) begin
      chk("pulse_width_a", run_a, PULSE_A);
      run_a = 0;
    end
  end

  task automatic wait_ack(input bit b, input int start, output int lat,
                          output logic [3:0] a, output logic e);
    lat = start;
    a   = '0;
    e   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      a = b ? ack_b : ack_a;
      e = b ? err_b : err_a;
      if (a != 0) break;
    end
    chk("ack_seen", |a, 1);
  endtask

  task automatic check_sb(input string tag, input int lat, input logic [3:0] a, input logic e);
    exp_t x;
    chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, "_ack"}, a, x.ack);
      chk({tag, "_err"}, e, x.err);
      chk({tag, "_lat"}, lat, x.lat);
    end
  endtask

  initial begin
    int         lat;
    logic [3:0] a;
    logic       e;

    rst_a = 1'b0; rst_b = 1'b0; stuck_a = '0;
    req_a = 4'hF; op_a = 4'b0110; idx_a = {3'd5, 3'd5, 3'd2, 3'd2};
    req_b = '0;   op_b = '0;      idx_b = '0;

    // Reset held with all requests high: nothing may move.
    repeat (2) begin
      @(negedge clk);
      chk("rst_s", s_a, 0);
      chk("rst_r", r_a, 0);
      chk("rst_ack", ack_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_err", err_a, 0);
    end

    // Contention: acks 0,1,2,3, first grant to requester 0.
    rst_a = 1'b1;
    for (int k = 0; k < 4; k++)
      sb.push_back('{4'(1 << k), 1'b0, (k == 0) ? PULSE_A + 1 + VX : PULSE_A + 2 + VX});
    for (int k = 0; k < 4; k++) begin
      wait_ack(1'b0, 0, lat, a, e);
      check_sb("contend", lat, a, e);
      req_a = req_a & ~a;
    end
    chk("contend_q2", q_a[2], 1);
    chk("contend_q5", q_a[5], 0);

    // Single set of idx 3 by requester 1.
    @(negedge clk);
    req_a = 4'b0010; op_a = 4'b0010; idx_a = {3'd0, 3'd0, 3'd3, 3'd0};
    sb.push_back('{4'b0010, 1'b0, PULSE_A + 1 + VX});
    @(negedge clk);
    chk("set_s", s_a, 8'h08);
    chk("set_r", r_a, 0);
    wait_ack(1'b0, 1, lat, a, e);
    check_sb("set", lat, a, e);
    req_a = '0;
    chk("set_q3", q_a[3], 1);

    // Stuck-low bit 4: read-back flags it only when verify is built in.
    @(negedge clk);
    stuck_a = 8'h10;
    req_a = 4'b0100; op_a = 4'b0100; idx_a = {3'd0, 3'd4, 3'd0, 3'd0};
    sb.push_back('{4'b0100, 1'(VX), PULSE_A + 1 + VX});
    wait_ack(1'b0, 0, lat, a, e);
    check_sb("stuck", lat, a, e);
    req_a = '0;
    chk("stuck_q4", q_a[4], 0);

    // Instance B: out-of-range index 7 on a 6-entry bank.
    @(negedge clk);
    rst_b = 1'b1;
    req_b = 4'b0001; op_b = 4'b0001; idx_b = {9'd0, 3'd7};
    sb.push_back('{4'b0001, 1'b1, 1});
    wait_ack(1'b1, 0, lat, a, e);
    check_sb("oor", lat, a, e);
    chk("oor_s", s_b, 0);
    chk("oor_r", r_b, 0);
    req_b = '0;

    // Reset in the 2nd cycle of a 4-cycle pulse from requester 2 (rr becomes 3).
    @(negedge clk);
    req_b = 4'b0100; op_b = 4'b0100; idx_b = {3'd0, 3'd1, 3'd0, 3'd0};
    @(negedge clk);
    chk("mid_s_first", s_b, 6'h02);
    @(negedge clk);
    rst_b = 1'b0; req_b = '0;
    @(negedge clk);
    chk("mid_rst_s", s_b, 0);
    chk("mid_rst_r", r_b, 0);
    chk("mid_rst_ack", ack_b, 0);
    chk("mid_rst_busy", busy_b, 0);
    @(negedge clk);
    chk("mid_rst_ack2", ack_b, 0);
    // rr must be back at 0, so requester 0 wins over 3.
    rst_b = 1'b1;
    req_b = 4'hF; op_b = 4'hF; idx_b = '0;
    sb.push_back('{4'b0001, 1'b0, PULSE_B + 1 + VX});
    wait_ack(1'b1, 0, lat, a, e);
    check_sb("after_rst", lat, a, e);
    req_b = '0;
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
